mem_port_arbiter: RTL and testbench

Shares the single memory port of the multicycle rv32i core between two requesters: instruction fetch (I) and load/store (D). It arbitrates, drives mem_addr, mem_wr_data and mem_wr_ena, counts the memory read latency, and returns read data to the winning requester. It replaces the fixed PC-to-mem_addr connection, so loads and stores can reach memory.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view. The master modport is the surrounding core and memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ena;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wr_data;
  logic              d_wr_ena;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ena;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;

  modport slave (
    input  ena, i_req, i_addr, d_req, d_addr, d_wr_data, d_wr_ena, mem_rd_data,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wr_data, mem_wr_ena, busy
  );

  modport master (
    output ena, i_req, i_addr, d_req, d_addr, d_wr_data, d_wr_ena, mem_rd_data,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wr_data, mem_wr_ena, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (I) and load/store (D).
// One read is in flight at a time. Stores complete in their grant cycle.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned PRIORITY_MODE = 0
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {StIdle, StWait} state_e;

  localparam logic [2:0] Latency = 3'(READ_LATENCY);

  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // last_d_q doubles as the owner of the read in flight while in StWait.
  logic              last_d_q, last_d_d;
  logic              i_rvalid_q, d_rvalid_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic              i_gnt, d_gnt, pick_d, capture, mem_wr_ena;
  logic [ADDR_W-1:0] mem_addr;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    last_d_d   = last_d_q;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    pick_d     = 1'b0;
    capture    = 1'b0;
    mem_wr_ena = 1'b0;
    mem_addr   = addr_q;
    unique case (state_q)
      StIdle: begin
        // Grants are gated by rst so nothing is granted while reset is held.
        if (rst && bus.ena && (bus.i_req || bus.d_req)) begin
          if (bus.i_req && bus.d_req) begin
            pick_d = (PRIORITY_MODE != 0) || !last_d_q;
          end else begin
            pick_d = bus.d_req;
          end
          if (pick_d) begin
            d_gnt    = 1'b1;
            mem_addr = bus.d_addr;
            addr_d   = bus.d_addr;
            last_d_d = 1'b1;
            if (bus.d_wr_ena) begin
              mem_wr_ena = 1'b1;
            end else begin
              state_d = StWait;
              count_d = Latency;
            end
          end else begin
            i_gnt    = 1'b1;
            mem_addr = bus.i_addr;
            addr_d   = bus.i_addr;
            last_d_d = 1'b0;
            state_d  = StWait;
            count_d  = Latency;
          end
        end
      end
      StWait: begin
        if (count_q <= 3'd1) begin
          capture = 1'b1;
          state_d = StIdle;
          count_d = 3'd0;
        end else begin
          count_d = count_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      count_q    <= 3'd0;
      addr_q     <= '0;
      last_d_q   <= 1'b1;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      last_d_q   <= last_d_d;
      i_rvalid_q <= capture && !last_d_q;
      d_rvalid_q <= capture && last_d_q;
      if (capture && !last_d_q) i_rdata_q <= bus.mem_rd_data;
      if (capture && last_d_q)  d_rdata_q <= bus.mem_rd_data;
    end
  end

  assign bus.i_gnt       = i_gnt;
  assign bus.d_gnt       = d_gnt;
  assign bus.i_rvalid    = i_rvalid_q;
  assign bus.d_rvalid    = d_rvalid_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wr_data = bus.d_wr_data;
  assign bus.mem_wr_ena  = mem_wr_ena;
  assign bus.busy        = (state_q == StWait);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three configurations share one stimulus stream, and each vector row
// checks one of them. Memories model the read latency with an address delay line.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena, i_req, d_req, d_wr_ena;
  logic [31:0] i_addr, d_addr, d_wr_data;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

  assign if0.ena = ena; assign if0.i_req = i_req; assign if0.i_addr = i_addr;
  assign if0.d_req = d_req; assign if0.d_addr = d_addr; assign if0.d_wr_data = d_wr_data;
  assign if0.d_wr_ena = d_wr_ena;
  assign if1.ena = ena; assign if1.i_req = i_req; assign if1.i_addr = i_addr;
  assign if1.d_req = d_req; assign if1.d_addr = d_addr; assign if1.d_wr_data = d_wr_data;
  assign if1.d_wr_ena = d_wr_ena;
  assign if2.ena = ena; assign if2.i_req = i_req; assign if2.i_addr = i_addr;
  assign if2.d_req = d_req; assign if2.d_addr = d_addr; assign if2.d_wr_data = d_wr_data;
  assign if2.d_wr_ena = d_wr_ena;

  // dut 0: round robin, latency 1; dut 1: D priority, latency 1; dut 2: round robin, latency 3
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .PRIORITY_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .PRIORITY_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .PRIORITY_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h1111_0000;
      32'h0000_0010: mem_word = 32'h0050_0093;
      32'h0000_0200: mem_word = 32'hCAFE_0200;
      default:       mem_word = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  logic [31:0] ap0 [7];
  logic [31:0] ap1 [7];
  logic [31:0] ap2 [7];
  always @(posedge clk) begin
    ap0[0] <= if0.mem_addr;
    ap1[0] <= if1.mem_addr;
    ap2[0] <= if2.mem_addr;
    for (int k = 1; k < 7; k++) begin
      ap0[k] <= ap0[k-1];
      ap1[k] <= ap1[k-1];
      ap2[k] <= ap2[k-1];
    end
  end
  assign if0.mem_rd_data = mem_word(ap0[0]);
  assign if1.mem_rd_data = mem_word(ap1[0]);
  assign if2.mem_rd_data = mem_word(ap2[2]);

  typedef struct packed {
    logic        ig, dg;
    logic [31:0] ma;
    logic        we;
    logic [31:0] wd;
    logic        bz, irv, drv;
    logic [31:0] ird, drd;
  } obs_t;

  obs_t o [3];
  assign o[0] = '{if0.i_gnt, if0.d_gnt, if0.mem_addr, if0.mem_wr_ena, if0.mem_wr_data,
                  if0.busy, if0.i_rvalid, if0.d_rvalid, if0.i_rdata, if0.d_rdata};
  assign o[1] = '{if1.i_gnt, if1.d_gnt, if1.mem_addr, if1.mem_wr_ena, if1.mem_wr_data,
                  if1.busy, if1.i_rvalid, if1.d_rvalid, if1.i_rdata, if1.d_rdata};
  assign o[2] = '{if2.i_gnt, if2.d_gnt, if2.mem_addr, if2.mem_wr_ena, if2.mem_wr_data,
                  if2.busy, if2.i_rvalid, if2.d_rvalid, if2.i_rdata, if2.d_rdata};

  typedef struct {
    int          dut;
    bit          rs, en, ir;
    bit [31:0]   ia;
    bit          dr;
    bit [31:0]   da, dw;
    bit          dwe, eig, edg;
    bit [31:0]   ema;
    bit          ewe, ebz, eirv, edrv;
    bit [31:0]   erd;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input int dut, input bit rs, en, ir, input bit [31:0] ia, input bit dr,
                     input bit [31:0] da, dw, input bit dwe, eig, edg, input bit [31:0] ema,
                     input bit ewe, ebz, eirv, edrv, input bit [31:0] erd);
    vec_t v;
    v = '{dut, rs, en, ir, ia, dr, da, dw, dwe, eig, edg, ema, ewe, ebz, eirv, edrv, erd};
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  int lat;

  initial begin
    rst = 1'b0; ena = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr_ena = 1'b0;
    i_addr = '0; d_addr = '0; d_wr_data = '0;

    //   dut rs en ir ia     dr da      dw          dwe ig dg ema     we bz irv drv erd
    // single fetch, latency 1; first row holds reset with a request pending
    add(0, 0, 1, 1, 'h10,  0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 'h10,  0, 0,      0,          0,  1, 0, 'h10,   0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 'h10,  0, 0,      0,          0,  0, 0, 'h10,   0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 'h10,  0, 0,      0,          0,  0, 0, 'h10,   0, 0, 1, 0, 'h00500093);
    add(0, 1, 1, 0, 'h10,  0, 0,      0,          0,  0, 0, 'h10,   0, 0, 0, 0, 0);
    // round robin with both ports requesting
    add(0, 0, 1, 0, 0,     0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0,     1, 'h200,  0,          0,  1, 0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 0, 0,      0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 1, 'h200,  0, 0, 1, 0, 'h11110000);
    add(0, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 0, 'h200,  0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0,     1, 'h200,  0,          0,  1, 0, 0,      0, 0, 0, 1, 'hCAFE0200);
    add(0, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 0, 0,      0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 1, 'h200,  0, 0, 1, 0, 'h11110000);
    add(0, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 'h200,  0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 'h200,  0, 0, 0, 1, 'hCAFE0200);
    // fixed priority, same stimulus
    add(1, 0, 1, 0, 0,     0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 1, 'h200,  0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 0, 'h200,  0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0,     1, 'h200,  0,          0,  0, 1, 'h200,  0, 0, 0, 1, 'hCAFE0200);
    add(1, 1, 1, 1, 0,     0, 'h200,  0,          0,  0, 0, 'h200,  0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0,     0, 'h200,  0,          0,  1, 0, 0,      0, 0, 0, 1, 'hCAFE0200);
    add(1, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 0,      0, 1, 0, 0, 0);
    add(1, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 0,      0, 0, 1, 0, 'h11110000);
    // back-to-back stores, then a conflict between a fetch and a store
    add(0, 0, 1, 0, 0,     0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,     1, 'h100,  'hDEADBEEF, 1,  0, 1, 'h100,  1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,     1, 'h104,  'h1,        1,  0, 1, 'h104,  1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,     1, 'h108,  'h2,        1,  0, 1, 'h108,  1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,     0, 'h108,  'h2,        0,  0, 0, 'h108,  0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0,     0, 'h108,  'h2,        0,  0, 0, 'h108,  0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 'h10,  1, 'h10C,  'h3,        1,  1, 0, 'h10,   0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 'h10,  1, 'h10C,  'h3,        1,  0, 0, 'h10,   0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 'h10,  1, 'h10C,  'h3,        1,  0, 1, 'h10C,  1, 0, 1, 0, 'h00500093);
    add(0, 1, 1, 0, 'h10,  0, 'h10C,  'h3,        0,  0, 0, 'h10C,  0, 0, 0, 0, 0);
    // latency 3 with ena dropped after the grant
    add(2, 0, 1, 0, 0,     0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(2, 1, 1, 1, 'h10,  0, 0,      0,          0,  1, 0, 'h10,   0, 0, 0, 0, 0);
    add(2, 1, 0, 1, 'h40,  0, 0,      0,          0,  0, 0, 'h10,   0, 1, 0, 0, 0);
    add(2, 1, 0, 1, 'h40,  0, 0,      0,          0,  0, 0, 'h10,   0, 1, 0, 0, 0);
    add(2, 1, 0, 1, 'h40,  0, 0,      0,          0,  0, 0, 'h10,   0, 1, 0, 0, 0);
    add(2, 1, 0, 1, 'h40,  0, 0,      0,          0,  0, 0, 'h10,   0, 0, 1, 0, 'h00500093);
    add(2, 1, 0, 1, 'h40,  0, 0,      0,          0,  0, 0, 'h10,   0, 0, 0, 0, 0);
    add(2, 1, 1, 1, 'h40,  0, 0,      0,          0,  1, 0, 'h40,   0, 0, 0, 0, 0);
    add(2, 1, 0, 0, 'h40,  0, 0,      0,          0,  0, 0, 'h40,   0, 1, 0, 0, 0);
    // reset asserted one cycle into a latency-3 read
    add(2, 0, 1, 0, 0,     0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(2, 1, 1, 1, 'h10,  0, 0,      0,          0,  1, 0, 'h10,   0, 0, 0, 0, 0);
    add(2, 0, 1, 0, 'h10,  0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(2, 1, 1, 0, 'h10,  0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(2, 1, 1, 0, 'h10,  0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(2, 1, 1, 0, 'h10,  0, 0,      0,          0,  0, 0, 0,      0, 0, 0, 0, 0);
    add(2, 1, 1, 0, 0,     1, 'h200,  0,          0,  0, 1, 'h200,  0, 0, 0, 0, 0);
    add(2, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 'h200,  0, 1, 0, 0, 0);
    add(2, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 'h200,  0, 1, 0, 0, 0);
    add(2, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 'h200,  0, 1, 0, 0, 0);
    add(2, 1, 1, 0, 0,     0, 'h200,  0,          0,  0, 0, 'h200,  0, 0, 0, 1, 'hCAFE0200);

    for (int n = 0; n < tbl.size(); n++) begin
      @(posedge clk); #1;
      rst = tbl[n].rs; ena = tbl[n].en; i_req = tbl[n].ir; i_addr = tbl[n].ia;
      d_req = tbl[n].dr; d_addr = tbl[n].da; d_wr_data = tbl[n].dw; d_wr_ena = tbl[n].dwe;
      @(negedge clk);
      chk("i_gnt", n, 32'(o[tbl[n].dut].ig), 32'(tbl[n].eig));
      chk("d_gnt", n, 32'(o[tbl[n].dut].dg), 32'(tbl[n].edg));
      chk("mem_addr", n, o[tbl[n].dut].ma, tbl[n].ema);
      chk("mem_wr_ena", n, 32'(o[tbl[n].dut].we), 32'(tbl[n].ewe));
      chk("busy", n, 32'(o[tbl[n].dut].bz), 32'(tbl[n].ebz));
      chk("i_rvalid", n, 32'(o[tbl[n].dut].irv), 32'(tbl[n].eirv));
      chk("d_rvalid", n, 32'(o[tbl[n].dut].drv), 32'(tbl[n].edrv));
      if (tbl[n].ewe)  chk("mem_wr_data", n, o[tbl[n].dut].wd, tbl[n].dw);
      if (tbl[n].eirv) chk("i_rdata", n, o[tbl[n].dut].ird, tbl[n].erd);
      if (tbl[n].edrv) chk("d_rdata", n, o[tbl[n].dut].drd, tbl[n].erd);
      if (!tbl[n].rs) begin
        chk("i_rdata_rst", n, o[tbl[n].dut].ird, 32'h0);
        chk("d_rdata_rst", n, o[tbl[n].dut].drd, 32'h0);
      end
    end

    // Latency-3 load measured from grant to d_rvalid, with a bounded wait.
    @(posedge clk); #1;
    rst = 1'b1; ena = 1'b1; i_req = 1'b0; d_req = 1'b1; d_addr = 32'h0; d_wr_ena = 1'b0;
    @(negedge clk);
    chk("seq_d_gnt", 0, 32'(if2.d_gnt), 32'h1);
    @(posedge clk); #1;
    d_req = 1'b0;
    lat = 1;
    while (!if2.d_rvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("seq_latency", 0, 32'(lat), 32'd4);
    chk("seq_d_rdata", 0, if2.d_rdata, 32'h1111_0000);
    chk("seq_no_i_rvalid", 0, 32'(if2.i_rvalid), 32'h0);
    @(posedge clk); #1;
    chk("seq_rvalid_pulse", 0, 32'(if2.d_rvalid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
